ctrl_pipe_gen: RTL and testbench

//  Parametrised control-word pipeline carrying decoded control bits from the decode stage to writeback.

---
 rtl/ctrl_pipe_if.sv | 25 ++
 rtl/ctrl_pipe_gen.sv | 61 ++++++
 tb/tb_ctrl_pipe_gen.sv | 123 ++++++++++++
 3 files changed

// File: rtl/ctrl_pipe_if.sv
// ctrl_pipe_if: control-word pipeline bus between the control unit, hazard logic and the pipeline.
interface ctrl_pipe_if #(
  parameter int CW     = 10,
  parameter int STAGES = 4,
  parameter int CNT_W  = 16
);
  logic [CW-1:0]        dec_word;
  logic                 dec_valid;
  logic                 stall_ld;
  logic                 stall_miss;
  logic                 flush;
  logic [STAGES*CW-1:0] stage_word;
  logic [STAGES-1:0]    stage_valid;
  logic [CNT_W-1:0]     bubble_cnt;
  logic [CNT_W-1:0]     stall_cnt;
  logic [CNT_W-1:0]     flush_cnt;
  modport master (
    output dec_word, dec_valid, stall_ld, stall_miss, flush,
    input  stage_word, stage_valid, bubble_cnt, stall_cnt, flush_cnt
  );
  modport slave (
    input  dec_word, dec_valid, stall_ld, stall_miss, flush,
    output stage_word, stage_valid, bubble_cnt, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/ctrl_pipe_gen.sv
// ctrl_pipe_gen: decode-to-writeback control-word pipeline with stall, freeze, flush and saturating perf counters.
module ctrl_pipe_gen #(
  parameter int CW          = 10,
  parameter int STAGES      = 4,
  parameter int FLUSH_DEPTH = 2,
  parameter int CNT_W       = 16
) (
  input logic         clk,
  input logic         rst,
  ctrl_pipe_if.slave  bus
);
  logic [CW-1:0]     word_q [STAGES];
  logic [CW-1:0]     word_d [STAGES];
  logic [CW-1:0]     adv_w  [STAGES];
  logic [STAGES-1:0] valid_q, valid_d, adv_v;
  logic [CNT_W-1:0]  bubble_q, bubble_d, stall_q, stall_d, flush_q, flush_d;
  logic              ld_eff;
  assign ld_eff = bus.stall_ld & ~bus.stall_miss & ~bus.flush;
  for (genvar g = 0; g < STAGES; g++) begin : g_stage
    if (g == 0) begin : g_head
      assign adv_w[g] = bus.dec_word & {CW{bus.dec_valid}};
      assign adv_v[g] = bus.dec_valid;
    end else begin : g_tail
      assign adv_w[g] = word_q[g-1];
      assign adv_v[g] = valid_q[g-1];
    end
    assign bus.stage_word[g*CW +: CW] = word_q[g];
  end
  assign bus.stage_valid = valid_q;
  assign bus.bubble_cnt  = bubble_q;
  assign bus.stall_cnt   = stall_q;
  assign bus.flush_cnt   = flush_q;
  // Bubbles always carry word=0 so downstream gating can ignore valid.
  always_comb begin
    for (int i = 0; i < STAGES; i++) begin
      automatic logic kill = bus.flush & ((i < FLUSH_DEPTH) | ((i == FLUSH_DEPTH) & ~bus.stall_miss));
      automatic logic hold = ~kill & (bus.stall_miss | (bus.stall_ld & ~bus.flush & (i == 0)));
      automatic logic bub  = kill | (ld_eff & (i == 1));
      word_d[i]  = bub ? '0   : hold ? word_q[i]  : adv_w[i];
      valid_d[i] = bub ? 1'b0 : hold ? valid_q[i] : adv_v[i];
    end
    bubble_d = (ld_eff & ~&bubble_q) ? bubble_q + CNT_W'(1) : bubble_q;
    stall_d  = (bus.stall_miss & ~&stall_q) ? stall_q + CNT_W'(1) : stall_q;
    flush_d  = (bus.flush & ~&flush_q) ? flush_q + CNT_W'(1) : flush_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      word_q   <= '{default: '0};
      valid_q  <= '0;
      bubble_q <= '0;
      stall_q  <= '0;
      flush_q  <= '0;
    end else begin
      word_q   <= word_d;
      valid_q  <= valid_d;
      bubble_q <= bubble_d;
      stall_q  <= stall_d;
      flush_q  <= flush_d;
    end
  end
endmodule

// File: tb/tb_ctrl_pipe_gen.sv
// tb_ctrl_pipe_gen: directed and random checks of ctrl_pipe_gen against a slot-shifting reference model.
module tb_ctrl_pipe_gen;
  localparam int CW = 10, S = 4, FD = 2;
  logic clk = 0, rst = 1;
  int checks = 0, errors = 0;
  ctrl_pipe_if #(.CW(CW), .STAGES(S), .CNT_W(16)) bus ();
  ctrl_pipe_if #(.CW(CW), .STAGES(S), .CNT_W(4))  bus4 ();
  ctrl_pipe_gen #(.CW(CW), .STAGES(S), .FLUSH_DEPTH(FD), .CNT_W(16)) dut  (.clk(clk), .rst(rst), .bus(bus));
  ctrl_pipe_gen #(.CW(CW), .STAGES(S), .FLUSH_DEPTH(FD), .CNT_W(4))  dut4 (.clk(clk), .rst(rst), .bus(bus4));
  assign bus4.dec_word   = bus.dec_word;
  assign bus4.dec_valid  = bus.dec_valid;
  assign bus4.stall_ld   = bus.stall_ld;
  assign bus4.stall_miss = bus.stall_miss;
  assign bus4.flush      = bus.flush;
  always #5 clk = ~clk;
  logic [CW-1:0] mw [S];
  logic          mv [S];
  int mb, ms, mf;
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic drive(input logic [CW-1:0] w, input logic v, input logic ld, input logic miss, input logic fl);
    bus.dec_word = w; bus.dec_valid = v; bus.stall_ld = ld; bus.stall_miss = miss; bus.flush = fl;
  endtask
  task automatic kill_slot(input int i);
    mw[i] = '0; mv[i] = 0;
  endtask
  task automatic shift_from(input int lo);
    for (int i = S - 1; i > lo; i--) begin mw[i] = mw[i-1]; mv[i] = mv[i-1]; end
  endtask
  task automatic model_edge();
    if (rst) begin
      for (int i = 0; i < S; i++) kill_slot(i);
      mb = 0; ms = 0; mf = 0;
    end else if (bus.flush) begin
      mf++;
      if (bus.stall_miss) begin
        ms++;
        for (int i = 0; i < FD; i++) kill_slot(i);
      end else begin
        shift_from(0);
        for (int i = 0; i <= FD; i++) kill_slot(i);
      end
    end else if (bus.stall_miss) ms++;
    else if (bus.stall_ld) begin
      mb++;
      shift_from(1);
      kill_slot(1);
    end else begin
      shift_from(0);
      mv[0] = bus.dec_valid;
      mw[0] = bus.dec_valid ? bus.dec_word : '0;
    end
  endtask
  function automatic logic [63:0] sat(input int v, input int w);
    return 64'(v > (1 << w) - 1 ? (1 << w) - 1 : v);
  endfunction
  task automatic step();
    logic [S*CW-1:0] ew;
    logic [S-1:0] ev;
    model_edge();
    @(posedge clk);
    #1;
    for (int i = 0; i < S; i++) begin ew[i*CW +: CW] = mw[i]; ev[i] = mv[i]; end
    check("stage_word", 64'(bus.stage_word), 64'(ew));
    check("stage_valid", 64'(bus.stage_valid), 64'(ev));
    check("bubble_cnt", 64'(bus.bubble_cnt), sat(mb, 16));
    check("stall_cnt", 64'(bus.stall_cnt), sat(ms, 16));
    check("flush_cnt", 64'(bus.flush_cnt), sat(mf, 16));
    check("stall_cnt4", 64'(bus4.stall_cnt), sat(ms, 4));
    check("bubble_cnt4", 64'(bus4.bubble_cnt), sat(mb, 4));
  endtask
  task automatic reset_fill();
    rst = 1; drive('0, 0, 0, 0, 0); step();
    rst = 0;
    for (int k = 1; k <= 4; k++) begin drive(CW'(k), 1, 0, 0, 0); step(); end
  endtask
  initial begin
    drive('0, 0, 0, 0, 0);
    step();
    check("reset_word", 64'(bus.stage_word), 0);
    reset_fill();
    check("t1_s3", 64'(bus.stage_word[3*CW +: CW]), 1);
    check("t1_valid", 64'(bus.stage_valid), 4'b1111);
    drive(CW'(5), 1, 1, 0, 0); step();
    check("t2_word", 64'(bus.stage_word), 64'({10'd2, 10'd3, 10'd0, 10'd4}));
    check("t2_bubble", 64'(bus.bubble_cnt), 1);
    reset_fill();
    for (int k = 0; k < 3; k++) begin drive(CW'(9), 1, 1, 1, 0); step(); end
    check("t3_word", 64'(bus.stage_word), 64'({10'd1, 10'd2, 10'd3, 10'd4}));
    check("t3_stall", 64'(bus.stall_cnt), 3);
    check("t3_bubble", 64'(bus.bubble_cnt), 0);
    reset_fill();
    drive(CW'(5), 1, 1, 0, 1); step();
    check("t4_word", 64'(bus.stage_word), 64'({10'd2, 10'd0, 10'd0, 10'd0}));
    check("t4_valid", 64'(bus.stage_valid), 4'b1000);
    check("t4_flush", 64'(bus.flush_cnt), 1);
    reset_fill();
    drive(CW'(5), 1, 0, 1, 1); step();
    check("t4m_word", 64'(bus.stage_word), 64'({10'd1, 10'd2, 10'd0, 10'd0}));
    check("t4m_stall", 64'(bus.stall_cnt), 1);
    for (int k = 0; k < 20; k++) begin drive(CW'(k), 1, 0, 1, 0); step(); end
    check("t5_sat", 64'(bus4.stall_cnt), 4'hF);
    reset_fill();
    drive(CW'(7), 1, 1, 0, 0); step();
    rst = 1; step();
    check("t6_rst", 64'(bus.stage_valid), 0);
    rst = 0; drive(CW'(10'h2A), 1, 0, 0, 0); step();
    check("t6_s0", 64'(bus.stage_word[CW-1:0]), 10'h2A);
    for (int k = 0; k < 3000; k++) begin
      rst = ($urandom_range(0, 199) == 0);
      drive(CW'($urandom), $urandom_range(0, 3) != 0, $urandom_range(0, 5) == 0,
            $urandom_range(0, 7) == 0, $urandom_range(0, 9) == 0);
      step();
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
